ad9637_spi_responder: RTL and testbench

- SPI slave that emulates the AD9637 3-wire control port (CS, SCLK, bidirectional SDIO) against a local byte-wide register file.
- Lets the existing AD9637 SPI master be exercised in loopback on hardware and in simulation.
- Decodes 24-bit-or-longer frames: 16-bit instruction, then data bytes.
  - Writes go into the register file and are reported on a strobe port.
  - Read data is shifted back out on SDIO.

---
 rtl/ad9637_spi_pkg.sv | 24 ++
 rtl/ad9637_spi_responder_sync.sv | 43 ++++
 rtl/ad9637_spi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_ad9637_spi_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9637_spi_pkg.sv
// Shared definitions for the AD9637 control-port responder: FSM states,
// instruction word field positions and byte-count encodings.
package ad9637_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam int RW_BIT   = 15;
  localparam int W_MSB    = 14;
  localparam int W_LSB    = 13;
  localparam int ADDR_MSB = 12;
  localparam int SPI_AW   = ADDR_MSB + 1;

  localparam logic [1:0] W_ONE    = 2'b00;
  localparam logic [1:0] W_TWO    = 2'b01;
  localparam logic [1:0] W_THREE  = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

endpackage

// File: rtl/ad9637_spi_responder_sync.sv
// Oversampling synchronizer for the SPI pins, with edge pulses for sclk and cs
// taken from the last sync stage against one extra history flop.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cs,
  input  logic i_sclk,
  input  logic i_sdio,
  output logic o_sdio,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  // Each stage packs {cs, sclk, sdio}; idle bus is cs=1, sclk=1.
  logic [2:0] r_stage [SYNC_STAGES];
  logic [1:0] r_prev;
  logic       w_cs_s;
  logic       w_sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= 3'b110;
      r_prev <= 2'b11;
    end else begin
      r_stage[0] <= {i_cs, i_sclk, i_sdio};
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
      r_prev <= {w_cs_s, w_sclk_s};
    end
  end

  assign w_cs_s      = r_stage[SYNC_STAGES-1][2];
  assign w_sclk_s    = r_stage[SYNC_STAGES-1][1];
  assign o_sdio      = r_stage[SYNC_STAGES-1][0];
  assign o_sclk_rise = w_sclk_s & ~r_prev[0];
  assign o_sclk_fall = ~w_sclk_s & r_prev[0];
  assign o_cs_rise   = w_cs_s & ~r_prev[1];
  assign o_cs_fall   = ~w_cs_s & r_prev[1];

endmodule

// File: rtl/ad9637_spi_responder.sv
// AD9637-style 3-wire SPI slave backed by a local byte register file, used to
// loop back the AD9637 SPI master on hardware and in simulation.
module ad9637_spi_responder
  import ad9637_spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              sdio_in,
  output logic              sdio_out,
  output logic              sdio_oe,
  output logic              wr_valid,
  output logic [SPI_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic w_sdio, w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_cs       (spi_cs),
    .i_sclk     (spi_sclk),
    .i_sdio     (sdio_in),
    .o_sdio     (w_sdio),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall)
  );

  state_t            r_state;
  logic [3:0]        r_bitcnt;
  logic [14:0]       r_instr;
  logic [7:0]        r_byte;
  logic [SPI_AW-1:0] r_addr;
  logic [1:0]        r_left;
  logic              r_stream;
  logic              r_got_byte;
  logic              r_sdio_out, r_sdio_oe, r_wr_valid, r_busy, r_frame_err;
  logic [SPI_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [DEPTH];

  function automatic logic in_range(input logic [SPI_AW-1:0] a);
    return (a >> ADDR_W) == '0;
  endfunction

  logic [15:0]       w_instr;
  logic [7:0]        w_wbyte;
  logic              w_commit, w_we, w_count_done;
  logic [SPI_AW-1:0] w_addr_dec, w_rd_addr;
  logic [7:0]        w_rd_data;

  assign w_instr      = {r_instr, w_sdio};
  assign w_wbyte      = {r_byte[6:0], w_sdio};
  assign w_commit     = (r_state == ST_WDATA) && w_sclk_rise && (r_bitcnt == 4'd0);
  assign w_we         = w_commit && in_range(r_addr);
  assign w_count_done = !r_stream && (r_left == 2'd0);
  assign w_addr_dec   = r_addr - 1'b1;
  // The single read port serves the first byte (address straight from the
  // instruction) and every following byte (next decremented address).
  assign w_rd_addr    = (r_state == ST_INSTR) ? w_instr[ADDR_MSB:0] : w_addr_dec;
  assign w_rd_data    = in_range(w_rd_addr) ? r_mem[w_rd_addr[ADDR_W-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_we) begin
      r_mem[r_addr[ADDR_W-1:0]] <= w_wbyte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= 4'd0;
      r_instr     <= '0;
      r_byte      <= 8'h00;
      r_addr      <= '0;
      r_left      <= 2'd0;
      r_stream    <= 1'b0;
      r_got_byte  <= 1'b0;
      r_sdio_out  <= 1'b1;
      r_sdio_oe   <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_commit) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_addr;
        r_wr_data  <= w_wbyte;
      end

      case (r_state)
        ST_IDLE: begin
          r_sdio_oe <= 1'b0;
          r_busy    <= 1'b0;
          if (w_cs_fall) begin
            r_state    <= ST_INSTR;
            r_bitcnt   <= 4'd15;
            r_got_byte <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_INSTR: begin
          if (w_sclk_rise) begin
            r_instr <= w_instr[14:0];
            if (r_bitcnt == 4'd0) begin
              r_addr   <= w_instr[ADDR_MSB:0];
              r_left   <= w_instr[W_MSB:W_LSB];
              r_stream <= (w_instr[W_MSB:W_LSB] == W_STREAM);
              r_bitcnt <= 4'd7;
              if (w_instr[RW_BIT]) begin
                r_state <= ST_RDATA;
                r_byte  <= w_rd_data;
              end else begin
                r_state <= ST_WDATA;
              end
            end else begin
              r_bitcnt <= r_bitcnt - 4'd1;
            end
          end
        end

        ST_WDATA: begin
          if (w_sclk_rise) begin
            r_byte   <= w_wbyte;
            r_bitcnt <= r_bitcnt - 4'd1;
            if (r_bitcnt == 4'd0) begin
              r_addr     <= w_addr_dec;
              r_got_byte <= 1'b1;
              r_left     <= r_left - 2'd1;
              r_bitcnt   <= 4'd7;
              if (w_count_done) r_state <= ST_DONE;
            end
          end
        end

        ST_RDATA: begin
          if (w_sclk_fall) begin
            r_sdio_oe  <= 1'b1;
            r_sdio_out <= r_byte[r_bitcnt[2:0]];
          end
          if (w_sclk_rise) begin
            r_bitcnt <= r_bitcnt - 4'd1;
            if (r_bitcnt == 4'd0) begin
              r_addr     <= w_addr_dec;
              r_got_byte <= 1'b1;
              r_bitcnt   <= 4'd7;
              if (w_count_done) begin
                r_state   <= ST_DONE;
                r_sdio_oe <= 1'b0;
              end else begin
                r_byte <= w_rd_data;
                r_left <= r_left - 2'd1;
              end
            end
          end
        end

        ST_DONE: begin
          r_sdio_oe <= 1'b0;
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Early CS release; a byte completing on this same cycle still counts.
      if (w_cs_rise && (r_state == ST_INSTR || r_state == ST_WDATA || r_state == ST_RDATA)) begin
        r_state     <= ST_IDLE;
        r_sdio_oe   <= 1'b0;
        r_busy      <= 1'b0;
        r_frame_err <= !(r_got_byte || w_commit);
      end
    end
  end

  assign sdio_out  = r_sdio_out;
  assign sdio_oe   = r_sdio_oe;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ad9637_spi_responder.sv
// Bench for ad9637_spi_responder: directed vector table, a reset-mid-frame
// sequence and random frames, all scored against a byte-level memory model.
module tb_ad9637_spi_responder;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst, spi_cs, spi_sclk, sdio_in;
  logic        sdio_out, sdio_oe, wr_valid, busy, frame_err;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  ad9637_spi_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .sdio_in(sdio_in),
    .sdio_out(sdio_out), .sdio_oe(sdio_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_err(frame_err)
  );

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [15:0] instr;
    int          nbits;
    logic [31:0] wd;
    int          exp_wr;
    logic [12:0] exp_wa;
    logic [7:0]  exp_wd;
    int          exp_err;
    logic [31:0] exp_rd;
    int          rd_n;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  wr_t        wr_q[$];
  int         err_cnt;
  logic [7:0] ref_mem [256];
  logic [7:0] g_wb [16];
  logic [7:0] g_rb [16];
  int         g_oe_cnt;
  logic       g_busy_seen;
  vec_t       vecs [12];

  always @(negedge clk) begin
    wr_t ev;
    if (wr_valid) begin
      ev.a = wr_addr;
      ev.d = wr_data;
      wr_q.push_back(ev);
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side: SDIO changes together with the SCLK fall, read data is
  // sampled at the instant SCLK is raised.
  task automatic spi_frame(input logic [15:0] instr, input int nbits);
    int k;
    for (int i = 0; i < 16; i++) g_rb[i] = 8'h00;
    g_oe_cnt = 0;
    spi_cs = 1'b0;
    tick(H);
    g_busy_seen = busy;
    for (int b = 0; b < nbits; b++) begin
      spi_sclk = 1'b0;
      if (b < 16) begin
        sdio_in = instr[15-b];
      end else begin
        k = b - 16;
        sdio_in = g_wb[k/8][7-(k%8)];
      end
      tick(H);
      spi_sclk = 1'b1;
      if (sdio_oe) g_oe_cnt++;
      if (b >= 16) begin
        k = b - 16;
        g_rb[k/8][7-(k%8)] = sdio_out;
      end
      tick(H);
    end
    tick(H);
    spi_cs = 1'b1;
    tick(3*H);
  endtask

  task automatic run_frame(input logic [15:0] instr, input int nbits);
    int          rw, w, nmax, dbits, neff, exp_oe;
    logic [12:0] a, ea;
    wr_q.delete();
    err_cnt = 0;
    spi_frame(instr, nbits);
    rw    = int'(instr[15]);
    w     = int'(instr[14:13]);
    a     = instr[12:0];
    nmax  = (w == 3) ? 1000 : w + 1;
    dbits = (nbits > 16) ? nbits - 16 : 0;
    neff  = dbits / 8;
    if (neff > nmax) neff = nmax;
    exp_oe = 0;
    if (rw == 1) exp_oe = (dbits < 8*nmax) ? dbits : 8*nmax;
    check("wr_count", wr_q.size(), (rw == 1) ? 0 : neff);
    for (int i = 0; i < neff; i++) begin
      ea = a - 13'(i);
      if (rw == 0) begin
        if (i < wr_q.size()) begin
          check("wr_addr", 32'(wr_q[i].a), 32'(ea));
          check("wr_data", 32'(wr_q[i].d), 32'(g_wb[i]));
        end
        if (ea < 13'd256) ref_mem[ea[7:0]] = g_wb[i];
      end else begin
        check("rd_data", 32'(g_rb[i]), (ea < 13'd256) ? 32'(ref_mem[ea[7:0]]) : 32'h0);
      end
    end
    check("frame_err", err_cnt, (nbits < 24) ? 1 : 0);
    check("oe_cycles", g_oe_cnt, exp_oe);
    check("busy_in_frame", 32'(g_busy_seen), 1);
    check("busy_after", 32'(busy), 0);
    check("oe_after", 32'(sdio_oe), 0);
    $display("frame instr=0x%04h bits=%0d writes=%0d frame_err=%0d oe=%0d rd0=0x%02h",
             instr, nbits, wr_q.size(), err_cnt, g_oe_cnt, g_rb[0]);
  endtask

  initial begin
    logic [15:0] instr;
    logic        rw_b;
    logic [1:0]  w_b;
    logic [12:0] a, last_a;
    logic [31:0] wd, rd;
    int          nb, nbits;

    vecs[0]  = '{16'h0014, 24, 32'hA5000000, 1, 13'h014, 8'hA5, 0, 32'h0, 0};
    vecs[1]  = '{16'h8014, 24, 32'h0,        0, 13'h000, 8'h00, 0, 32'hA5000000, 1};
    vecs[2]  = '{16'h4003, 40, 32'h11223300, 3, 13'h003, 8'h11, 0, 32'h0, 0};
    vecs[3]  = '{16'hC003, 40, 32'h0,        0, 13'h000, 8'h00, 0, 32'h11223300, 3};
    vecs[4]  = '{16'h0000, 24, 32'h5A000000, 1, 13'h000, 8'h5A, 0, 32'h0, 0};
    vecs[5]  = '{16'hE000, 32, 32'h0,        0, 13'h000, 8'h00, 0, 32'h5A000000, 2};
    vecs[6]  = '{16'h0020, 20, 32'hFF000000, 0, 13'h000, 8'h00, 1, 32'h0, 0};
    vecs[7]  = '{16'h0120, 24, 32'h77000000, 1, 13'h120, 8'h77, 0, 32'h0, 0};
    vecs[8]  = '{16'h8120, 24, 32'h0,        0, 13'h000, 8'h00, 0, 32'h00000000, 1};
    vecs[9]  = '{16'h6050, 32, 32'hABCD0000, 2, 13'h050, 8'hAB, 0, 32'h0, 0};
    vecs[10] = '{16'hA050, 32, 32'h0,        0, 13'h000, 8'h00, 0, 32'hABCD0000, 2};
    vecs[11] = '{16'h8014, 20, 32'h0,        0, 13'h000, 8'h00, 1, 32'h0, 0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) g_wb[i] = 8'h00;
    rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b1; sdio_in = 1'b0;
    tick(5);
    check("rst_sdio_out", 32'(sdio_out), 1);
    check("rst_sdio_oe", 32'(sdio_oe), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    tick(5);

    for (int v = 0; v < 12; v++) begin
      wd = vecs[v].wd;
      g_wb[0] = wd[31:24]; g_wb[1] = wd[23:16]; g_wb[2] = wd[15:8]; g_wb[3] = wd[7:0];
      run_frame(vecs[v].instr, vecs[v].nbits);
      check("vec_wr_count", wr_q.size(), vecs[v].exp_wr);
      if (vecs[v].exp_wr > 0 && wr_q.size() > 0) begin
        check("vec_wr_addr", 32'(wr_q[0].a), 32'(vecs[v].exp_wa));
        check("vec_wr_data", 32'(wr_q[0].d), 32'(vecs[v].exp_wd));
      end
      check("vec_frame_err", err_cnt, vecs[v].exp_err);
      rd = vecs[v].exp_rd;
      for (int i = 0; i < vecs[v].rd_n; i++)
        check("vec_rd_byte", 32'(g_rb[i]), 32'(rd[31-8*i -: 8]));
    end

    // Reset ten bits into a read of 0x014, then confirm a cleared, working slave.
    err_cnt = 0;
    wr_q.delete();
    instr = 16'h8014;
    spi_cs = 1'b0;
    tick(H);
    for (int b = 0; b < 10; b++) begin
      spi_sclk = 1'b0; sdio_in = instr[15-b]; tick(H);
      spi_sclk = 1'b1; tick(H);
    end
    rst = 1'b1;
    tick(2);
    spi_cs = 1'b1;
    tick(6);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    check("midrst_frame_err", err_cnt, 0);
    check("midrst_wr_count", wr_q.size(), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_oe", 32'(sdio_oe), 0);
    check("midrst_sdio_out", 32'(sdio_out), 1);
    $display("reset mid-frame: busy=%0d oe=%0d frame_err_pulses=%0d", busy, sdio_oe, err_cnt);
    run_frame(16'h8014, 24);
    check("midrst_rd_cleared", 32'(g_rb[0]), 0);
    g_wb[0] = 8'h3C;
    run_frame(16'h0014, 24);
    run_frame(16'h8014, 24);
    check("midrst_rd_back", 32'(g_rb[0]), 32'h3C);

    last_a = 13'h014;
    for (int t = 0; t < 30; t++) begin
      rw_b = 1'($urandom_range(0, 1));
      w_b  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 13'($urandom_range(0, 8191));
        1: a = 13'h1FFF - 13'($urandom_range(0, 2));
        default: a = rw_b ? last_a : 13'($urandom_range(0, 255));
      endcase
      if (!rw_b) last_a = a;
      nb = (w_b == 2'b11) ? $urandom_range(1, 4) : int'(w_b) + 1;
      nbits = 16 + 8*nb;
      if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, 16 + 8*nb + 3);
      for (int i = 0; i < 16; i++) g_wb[i] = 8'($urandom_range(0, 255));
      run_frame({rw_b, w_b, a}, nbits);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
